rf_2r1w_init: RTL and testbench
===============================

Name: rf_2r1w_init

Overview:
- Parametrised successor to the 8x32 single-read register file.
- Provides one write port and two independent read ports.
- Read outputs are registered (1-cycle latency), with optional write-to-read bypass.
- A built-in init sequencer sweeps every entry to a programmable value, one entry per cycle.
- Sits between the datapath controller and the ALU operand muxes.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- BYPASS, 1, 1 = read of the address written in the same cycle returns new data; 0 = returns old data.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- wAddr  in  ADDR_W  write address.
- wData  in  DATA_W  write data.
- re0  in  1  read enable, port 0.
- rAddr0  in  ADDR_W  read address, port 0.
- rData0  out  DATA_W  registered read data, port 0.
- rValid0  out  1  rData0 updated this cycle.
- re1  in  1  read enable, port 1.
- rAddr1  in  ADDR_W  read address, port 1.
- rData1  out  DATA_W  registered read data, port 1.
- rValid1  out  1  rData1 updated this cycle.
- init_req  in  1  start init sweep (level sampled in IDLE).
- init_val  in  DATA_W  value written to all entries; captured when the sweep starts.
- busy  out  1  sweep in progress.
- init_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (clear=0, asynchronous):
  - all entries, rData0/1 and captured init value = 0;
  - rValid0/1, busy, init_done = 0;
  - FSM = IDLE, sweep counter = 0.
- Write: on a clk edge with we=1 in IDLE or DONE, entry[wAddr] <= wData.
- Read, per port, independent:
  - Cycle N with reN=1: at edge N+1, rDataN <= entry[rAddrN] and rValidN=1 for that cycle.
  - With reN=0: rDataN holds and rValidN=0.
  - Both ports may read the same address in the same cycle.
- Bypass: the effective write is either the external write or the sweep write.
  - If it targets rAddrN in the same cycle and BYPASS=1, rDataN gets the write data.
  - With BYPASS=0, rDataN gets the pre-write contents.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when init_req=1. init_val is captured and the counter is set to 0.
  - SWEEP: each cycle writes entry[counter] <= captured value, then counter increments. busy=1.
  - SWEEP -> DONE after writing entry DEPTH-1, so SWEEP lasts exactly DEPTH cycles.
  - DONE: init_done=1 for one cycle, busy=0, then unconditionally -> IDLE.
  - init_req held high in DONE does not restart the sweep; a new request is accepted in IDLE.
- During SWEEP:
  - External we is ignored (dropped, not queued).
  - Reads are allowed and return current contents: entries already swept give the new value, the rest give old values (bypass rules apply to the sweep write).
  - init_req is ignored.
- Simultaneous we and init_req in IDLE: the write commits that edge, the sweep starts next cycle and later overwrites it.
- Counter is ADDR_W bits and does not wrap past DEPTH-1. The transition is taken on counter == DEPTH-1.
- Reset asserted mid-sweep: immediate return to IDLE with all entries zero. There is no partial-sweep residue.
- Out-of-range addresses are impossible, since the address width exactly covers DEPTH.

Decomposition:
- Shared package rf_pkg holds:
  - the state encoding localparams (IDLE=2'b00, SWEEP=2'b01, DONE=2'b10);
  - the default DATA_W and ADDR_W.
- Sub-module rf_read_port: registered read with bypass compare and rValid generation, instantiated twice.
- Storage array, write arbitration (external vs sweep) and the FSM live in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5, then read port 0 addr 5 next cycle -> rData0=0xDEADBEEF with rValid0=1, exactly one cycle after re0.
- Same cycle: we=1 addr 3 data 0x11111111, re0 addr 3, re1 addr 3.
  - BYPASS=1 -> both ports return 0x11111111.
  - BYPASS=0 -> both return the prior value 0x00000000.
- init_req with init_val=0xA5A5A5A5 (DEPTH=8) -> busy high for exactly 8 cycles, init_done single pulse; reads of all 8 addresses return 0xA5A5A5A5.
- we=1 addr 2 data 0x12345678 during the 3rd sweep cycle -> write dropped; addr 2 reads 0xA5A5A5A5 after DONE.
- Assert clear during the 4th sweep cycle -> busy=0 immediately, FSM IDLE, all reads return 0, no init_done pulse.
- Simultaneous we (addr 7, 0xCAFEF00D) and init_req (0x0) in IDLE -> after the sweep, addr 7 reads 0x00000000. Port 1 read of addr 7 issued the cycle after the write, before the sweep reaches entry 7 -> returns 0xCAFEF00D.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the 2-read/1-write register file: state encoding
// and default geometry.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SWEEP = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: captures array data (or same-cycle write data
// when bypass is enabled) and flags the cycle in which the data updated.
import rf_pkg::*;

module rf_read_port #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid
);

    logic hit;

    assign hit = (BYPASS != 0) && wr_en && (wr_addr == r_addr);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= re;
            if (re) begin
                r_data <= hit ? wr_data : mem_data;
            end
        end
    end

endmodule

// File: rtl/rf_2r1w_init.sv
// 2-read/1-write register file with registered reads and a sequencer that
// sweeps every entry to a captured init value, one entry per cycle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | normal operation, external writes accepted, init_req sampled
// SWEEP | writing captured value to entry[cnt], external writes dropped
// DONE  | sweep finished, init_done pulse, external writes accepted
import rf_pkg::*;

module rf_2r1w_init #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              re0,
    input  logic [ADDR_W-1:0] rAddr0,
    output logic [DATA_W-1:0] rData0,
    output logic              rValid0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] rAddr1,
    output logic [DATA_W-1:0] rData1,
    output logic              rValid1,
    input  logic              init_req,
    input  logic [DATA_W-1:0] init_val,
    output logic              busy,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] init_q;
    logic              sweep_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (init_req) state_nxt = ST_SWEEP;
            ST_SWEEP: if (cnt == LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        init_done = 1'b0;
        sweep_we  = 1'b0;
        case (state)
            ST_SWEEP: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
            end
            ST_DONE:  init_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt    <= '0;
            init_q <= '0;
        end else if (state == ST_IDLE && init_req) begin
            cnt    <= '0;
            init_q <= init_val;
        end else if (state == ST_SWEEP) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Sweep owns the write port while active; external writes are simply lost.
    assign wr_en   = sweep_we | (we & (state != ST_SWEEP));
    assign wr_addr = sweep_we ? cnt : wAddr;
    assign wr_data = sweep_we ? init_q : wData;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd0 (
        .clk      (clk),
        .clear    (clear),
        .re       (re0),
        .r_addr   (rAddr0),
        .mem_data (mem[rAddr0]),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .r_data   (rData0),
        .r_valid  (rValid0)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_rd1 (
        .clk      (clk),
        .clear    (clear),
        .re       (re1),
        .r_addr   (rAddr1),
        .mem_data (mem[rAddr1]),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .r_data   (rData1),
        .r_valid  (rValid1)
    );

endmodule

// File: tb/tb_rf_2r1w_init.sv
// Directed bench for rf_2r1w_init: a bypassing and a non-bypassing instance
// share one stimulus stream and are checked against hand-computed values.
module tb_rf_2r1w_init;

    logic        clk = 1'b0;
    logic        clear;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic        re0, re1;
    logic [2:0]  rAddr0, rAddr1;
    logic        init_req;
    logic [31:0] init_val;

    logic [31:0] rData0, rData1, nb_rData0, nb_rData1;
    logic        rValid0, rValid1, nb_rValid0, nb_rValid1;
    logic        busy, init_done, nb_busy, nb_init_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_2r1w_init #(.DATA_W(32), .ADDR_W(3), .BYPASS(1)) u_dut (
        .clk(clk), .clear(clear), .we(we), .wAddr(wAddr), .wData(wData),
        .re0(re0), .rAddr0(rAddr0), .rData0(rData0), .rValid0(rValid0),
        .re1(re1), .rAddr1(rAddr1), .rData1(rData1), .rValid1(rValid1),
        .init_req(init_req), .init_val(init_val), .busy(busy), .init_done(init_done)
    );

    rf_2r1w_init #(.DATA_W(32), .ADDR_W(3), .BYPASS(0)) u_dut_nb (
        .clk(clk), .clear(clear), .we(we), .wAddr(wAddr), .wData(wData),
        .re0(re0), .rAddr0(rAddr0), .rData0(nb_rData0), .rValid0(nb_rValid0),
        .re1(re1), .rAddr1(rAddr1), .rData1(nb_rData1), .rValid1(nb_rValid1),
        .init_req(init_req), .init_val(init_val), .busy(nb_busy), .init_done(nb_init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b0; we = 1'b0; wAddr = '0; wData = '0;
        re0 = 1'b0; re1 = 1'b0; rAddr0 = '0; rAddr1 = '0;
        init_req = 1'b0; init_val = '0;

        // reset state
        #2;
        chk("rst_rData0", rData0, 32'h0);
        chk("rst_rData1", rData1, 32'h0);
        chk("rst_rValid0", {31'b0, rValid0}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_init_done", {31'b0, init_done}, 32'h0);
        #10;
        clear = 1'b1;

        // write then read, one-cycle latency
        we = 1'b1; wAddr = 3'd5; wData = 32'hDEADBEEF;
        step();
        chk("wr_no_valid_yet", {31'b0, rValid0}, 32'h0);
        we = 1'b0; re0 = 1'b1; rAddr0 = 3'd5;
        step();
        chk("rd5_data", rData0, 32'hDEADBEEF);
        chk("rd5_valid", {31'b0, rValid0}, 32'h1);
        chk("rd5_p1_idle", {31'b0, rValid1}, 32'h0);
        re0 = 1'b0;
        step();
        chk("rd5_valid_drop", {31'b0, rValid0}, 32'h0);
        chk("rd5_hold", rData0, 32'hDEADBEEF);

        // same-cycle write and dual read of the same address
        we = 1'b1; wAddr = 3'd3; wData = 32'h11111111;
        re0 = 1'b1; rAddr0 = 3'd3; re1 = 1'b1; rAddr1 = 3'd3;
        step();
        chk("byp_p0", rData0, 32'h11111111);
        chk("byp_p1", rData1, 32'h11111111);
        chk("nobyp_p0", nb_rData0, 32'h0);
        chk("nobyp_p1", nb_rData1, 32'h0);
        chk("byp_v1", {31'b0, rValid1}, 32'h1);
        we = 1'b0;
        step();
        chk("nobyp_after_p0", nb_rData0, 32'h11111111);
        chk("nobyp_after_p1", nb_rData1, 32'h11111111);
        re0 = 1'b0; re1 = 1'b0;

        // init sweep with a dropped write in the 3rd sweep cycle
        init_req = 1'b1; init_val = 32'hA5A5A5A5;
        step();
        init_req = 1'b0; init_val = 32'h0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sweep_busy_%0d", i), {31'b0, busy}, 32'h1);
            chk($sformatf("sweep_nodone_%0d", i), {31'b0, init_done}, 32'h0);
            we = (i == 2); wAddr = 3'd2; wData = 32'h12345678;
            step();
        end
        we = 1'b0;
        chk("done_busy", {31'b0, busy}, 32'h0);
        chk("done_pulse", {31'b0, init_done}, 32'h1);
        chk("done_pulse_nb", {31'b0, nb_init_done}, 32'h1);
        init_req = 1'b1;
        step();
        chk("done_single", {31'b0, init_done}, 32'h0);
        chk("done_to_idle", {31'b0, busy}, 32'h0);
        init_req = 1'b0;
        step();
        chk("no_restart", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            re0 = 1'b1; rAddr0 = 3'(i); re1 = 1'b1; rAddr1 = 3'(7 - i);
            step();
            chk($sformatf("swept_p0_%0d", i), rData0, 32'hA5A5A5A5);
            chk($sformatf("swept_p1_%0d", 7 - i), rData1, 32'hA5A5A5A5);
            chk($sformatf("swept_nb_p0_%0d", i), nb_rData0, 32'hA5A5A5A5);
        end
        re0 = 1'b0; re1 = 1'b0;

        // reset during the 4th sweep cycle
        init_req = 1'b1; init_val = 32'h77777777;
        step();
        init_req = 1'b0;
        step(); step(); step();
        chk("pre_clear_busy", {31'b0, busy}, 32'h1);
        #2;
        clear = 1'b0;
        #1;
        chk("clear_busy", {31'b0, busy}, 32'h0);
        chk("clear_rData0", rData0, 32'h0);
        chk("clear_rData1", rData1, 32'h0);
        #2;
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("clear_nodone_%0d", i), {31'b0, init_done}, 32'h0);
            chk($sformatf("clear_idle_%0d", i), {31'b0, busy}, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            re0 = 1'b1; rAddr0 = 3'(i); re1 = 1'b1; rAddr1 = 3'(i);
            step();
            chk($sformatf("cleared_p0_%0d", i), rData0, 32'h0);
            chk($sformatf("cleared_p1_%0d", i), rData1, 32'h0);
        end
        re0 = 1'b0; re1 = 1'b0;

        // simultaneous write and init request in IDLE
        we = 1'b1; wAddr = 3'd7; wData = 32'hCAFEF00D;
        init_req = 1'b1; init_val = 32'h0;
        step();
        we = 1'b0; init_req = 1'b0;
        re1 = 1'b1; rAddr1 = 3'd7;
        step();
        chk("early_p1_7", rData1, 32'hCAFEF00D);
        chk("early_p1_7_nb", nb_rData1, 32'hCAFEF00D);
        chk("early_v1", {31'b0, rValid1}, 32'h1);
        re1 = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("sweep_last_busy", {31'b0, busy}, 32'h1);
        re0 = 1'b1; rAddr0 = 3'd7;
        step();
        chk("sweep_byp_7", rData0, 32'h0);
        chk("sweep_nobyp_7", nb_rData0, 32'hCAFEF00D);
        chk("sweep2_done", {31'b0, init_done}, 32'h1);
        step();
        chk("final_p0_7", rData0, 32'h0);
        chk("final_nb_p0_7", nb_rData0, 32'h0);
        re0 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
